// File: rtl/tp_spawner.sv
// tp_spawner: spawns falling objects for a catch game, tracks score/lives.
// Ports: clk, rst_n (sync, active-low), frame_tick, start, pause, hit in;
//        show, id, midx, midy, score, lives, miss, game_over out (registered).
module tp_spawner #(
   parameter int unsigned X_MIN       = 64,
   parameter int unsigned Y_START     = 20,
   parameter int unsigned Y_BOTTOM    = 460,
   parameter int unsigned WAIT_FRAMES = 30,
   parameter int unsigned LIVES       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       pause,
   input  logic       hit,
   output logic       show,
   output logic [1:0] id,
   output logic [9:0] midx,
   output logic [9:0] midy,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic       miss,
   output logic       game_over
);

   typedef enum logic [1:0] {IDLE, WAIT, FALL, OVER} state_t;

   localparam logic [9:0]  X_MIN_V  = 10'(X_MIN);
   localparam logic [9:0]  Y_START_V = 10'(Y_START);
   localparam logic [9:0]  Y_BOT_V  = 10'(Y_BOTTOM);
   localparam logic [10:0] Y_BOT_W  = 11'(Y_BOTTOM);
   localparam logic [15:0] WAIT_V   = 16'(WAIT_FRAMES);
   localparam logic [1:0]  LIVES_V  = 2'(LIVES);
   localparam logic [15:0] SEED     = 16'hACE1;

   state_t      state, state_n;
   logic [15:0] lfsr, lfsr_n;
   logic [15:0] fc, fc_n;
   logic [4:0]  spawn_cnt, spawn_cnt_n;
   logic        show_n;
   logic [1:0]  id_n;
   logic [9:0]  midx_n;
   logic [9:0]  midy_n;
   logic [7:0]  score_n;
   logic [1:0]  lives_n;
   logic        miss_n;
   logic        game_over_n;

   logic        eff;
   logic [1:0]  level;
   logic [9:0]  speed;
   logic [10:0] floor_sum;
   logic [15:0] fc_inc;

   assign eff       = frame_tick & ~pause;
   // spawn_cnt saturates at 31, so its top two bits are min(cnt/8, 3)
   assign level     = spawn_cnt[4:3];
   assign speed     = 10'(level) + 10'd1;
   // one extra bit so the floor test cannot wrap
   assign floor_sum = {1'b0, midy} + {1'b0, speed};
   assign fc_inc    = fc + 16'd1;

   always_comb begin
      state_n     = state;
      lfsr_n      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      fc_n        = fc;
      spawn_cnt_n = spawn_cnt;
      show_n      = show;
      id_n        = id;
      midx_n      = midx;
      midy_n      = midy;
      score_n     = score;
      lives_n     = lives;
      miss_n      = 1'b0;
      game_over_n = game_over;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_n     = WAIT;
               fc_n        = '0;
               score_n     = '0;
               lives_n     = LIVES_V;
               spawn_cnt_n = '0;
            end
         end
         WAIT: begin
            if (eff) begin
               fc_n = fc_inc;
               if (fc_inc == WAIT_V) begin
                  state_n = FALL;
                  show_n  = 1'b1;
                  id_n    = lfsr[1:0];
                  midx_n  = X_MIN_V + {1'b0, lfsr[14:6]};
                  midy_n  = Y_START_V;
                  if (spawn_cnt != 5'd31)
                     spawn_cnt_n = spawn_cnt + 5'd1;
               end
            end
         end
         FALL: begin
            // a catch wins over floor contact and ignores pause
            if (hit) begin
               state_n = WAIT;
               show_n  = 1'b0;
               fc_n    = '0;
               if (score != 8'hFF)
                  score_n = score + 8'd1;
            end else if (eff) begin
               if (floor_sum >= Y_BOT_W) begin
                  midy_n  = Y_BOT_V;
                  show_n  = 1'b0;
                  miss_n  = 1'b1;
                  lives_n = lives - 2'd1;
                  fc_n    = '0;
                  if (lives == 2'd1) begin
                     state_n     = OVER;
                     game_over_n = 1'b1;
                  end else begin
                     state_n = WAIT;
                  end
               end else begin
                  midy_n = midy + speed;
               end
            end
         end
         OVER: begin
            show_n      = 1'b0;
            game_over_n = 1'b1;
            if (start) begin
               state_n     = WAIT;
               fc_n        = '0;
               score_n     = '0;
               lives_n     = LIVES_V;
               spawn_cnt_n = '0;
               game_over_n = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         lfsr      <= SEED;
         fc        <= '0;
         spawn_cnt <= '0;
         show      <= 1'b0;
         id        <= '0;
         midx      <= '0;
         midy      <= Y_START_V;
         score     <= '0;
         lives     <= LIVES_V;
         miss      <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_n;
         lfsr      <= lfsr_n;
         fc        <= fc_n;
         spawn_cnt <= spawn_cnt_n;
         show      <= show_n;
         id        <= id_n;
         midx      <= midx_n;
         midy      <= midy_n;
         score     <= score_n;
         lives     <= lives_n;
         miss      <= miss_n;
         game_over <= game_over_n;
      end
   end

endmodule

// File: tb/tb_tp_spawner.sv
// tb_tp_spawner: scoreboard bench for tp_spawner.
// A behavioural game model queues expected outputs; each cycle pops and compares.
module tb_tp_spawner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       hit = 1'b0;
   logic       show;
   logic [1:0] id;
   logic [9:0] midx;
   logic [9:0] midy;
   logic [7:0] score;
   logic [1:0] lives;
   logic       miss;
   logic       game_over;

   always #5 clk = ~clk;

   tp_spawner dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
      .start(start), .pause(pause), .hit(hit),
      .show(show), .id(id), .midx(midx), .midy(midy),
      .score(score), .lives(lives), .miss(miss),
      .game_over(game_over)
   );

   typedef struct {
      logic       show;
      logic [1:0] id;
      logic [9:0] midx;
      logic [9:0] midy;
      logic [7:0] score;
      logic [1:0] lives;
      logic       miss;
      logic       over;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_pass = 0;

   // model state: 0 idle, 1 wait, 2 fall, 3 over
   int m_st, m_fc, m_spawn, m_id, m_midx, m_midy, m_score, m_lives;
   logic m_show, m_miss, m_over;
   logic [15:0] m_lfsr, m_last_lf;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   task automatic step(input logic r, input logic ft, input logic st,
                       input logic pa, input logic ht);
      exp_t e;
      logic eff;
      int spd;
      logic [15:0] lf;
      @(negedge clk);
      rst_n = r; frame_tick = ft; start = st; pause = pa; hit = ht;
      lf = m_lfsr;
      eff = ft && !pa;
      m_miss = 1'b0;
      if (!r) begin
         m_st = 0; m_fc = 0; m_spawn = 0; m_show = 0; m_id = 0;
         m_midx = 0; m_midy = 20; m_score = 0; m_lives = 3;
         m_over = 0; m_lfsr = 16'hACE1;
      end else begin
         m_lfsr = {lf[14:0], ^(lf & 16'hB400)};
         if (st && (m_st == 0 || m_st == 3)) begin
            m_st = 1; m_fc = 0; m_score = 0; m_lives = 3;
            m_spawn = 0; m_over = 0;
         end else if (m_st == 1) begin
            if (eff) begin
               m_fc++;
               if (m_fc == 30) begin
                  m_st = 2; m_show = 1; m_id = int'(lf & 16'h3);
                  m_midx = 64 + int'((lf >> 6) & 16'h1FF);
                  m_midy = 20; m_last_lf = lf;
                  if (m_spawn < 31) m_spawn++;
               end
            end
         end else if (m_st == 2) begin
            spd = 1 + ((m_spawn / 8 > 3) ? 3 : m_spawn / 8);
            if (ht) begin
               m_show = 0; m_fc = 0; m_st = 1;
               if (m_score < 255) m_score++;
            end else if (eff) begin
               if (m_midy + spd >= 460) begin
                  m_midy = 460; m_show = 0; m_miss = 1;
                  m_lives--; m_fc = 0;
                  if (m_lives == 0) begin m_st = 3; m_over = 1; end
                  else m_st = 1;
               end else begin
                  m_midy += spd;
               end
            end
         end
      end
      e.show = m_show; e.id = 2'(m_id); e.midx = 10'(m_midx);
      e.midy = 10'(m_midy); e.score = 8'(m_score);
      e.lives = 2'(m_lives); e.miss = m_miss; e.over = m_over;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("sb_show",  16'(show),      16'(e.show));
      chk("sb_id",    16'(id),        16'(e.id));
      chk("sb_midx",  16'(midx),      16'(e.midx));
      chk("sb_midy",  16'(midy),      16'(e.midy));
      chk("sb_score", 16'(score),     16'(e.score));
      chk("sb_lives", 16'(lives),     16'(e.lives));
      chk("sb_miss",  16'(miss),      16'(e.miss));
      chk("sb_over",  16'(game_over), 16'(e.over));
   endtask

   task automatic tick();
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
   endtask

   task automatic wait_spawn();
      for (int i = 0; i < 100 && !show; i++) tick();
      chk("spawn_seen", 16'(show), 16'd1);
   endtask

   task automatic fall_floor();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         step(1, 1, 0, 0, 0);
         if (miss) seen = 1'b1;
         else step(1, 0, 0, 0, 0);
      end
      chk("miss_seen", 16'(miss), 16'd1);
   endtask

   task automatic chk_reset();
      chk("rst_show",  16'(show),      16'd0);
      chk("rst_id",    16'(id),        16'd0);
      chk("rst_midx",  16'(midx),      16'd0);
      chk("rst_midy",  16'(midy),      16'd20);
      chk("rst_score", 16'(score),     16'd0);
      chk("rst_lives", 16'(lives),     16'd3);
      chk("rst_miss",  16'(miss),      16'd0);
      chk("rst_over",  16'(game_over), 16'd0);
   endtask

   initial begin
      // reset, start, spawn on the 30th tick
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk_reset();
      step(1, 0, 1, 0, 0);
      for (int i = 0; i < 29; i++) tick();
      chk("pre_spawn", 16'(show), 16'd0);
      step(1, 1, 0, 0, 0);
      chk("spawn_show", 16'(show), 16'd1);
      chk("spawn_midy", 16'(midy), 16'd20);
      chk("spawn_id", 16'(id), 16'(m_last_lf[1:0]));
      chk("midx_range", 16'(midx >= 10'd64 && midx <= 10'd575), 16'd1);
      step(1, 0, 0, 0, 0);

      // level-0 fall to the floor
      tick();
      chk("fall_21", 16'(midy), 16'd21);
      tick();
      chk("fall_22", 16'(midy), 16'd22);
      fall_floor();
      chk("floor_midy", 16'(midy), 16'd460);
      chk("floor_lives", 16'(lives), 16'd2);
      chk("floor_show", 16'(show), 16'd0);
      step(1, 0, 0, 0, 0);
      chk("miss_pulse", 16'(miss), 16'd0);

      // hit and floor contact together
      wait_spawn();
      for (int i = 0; i < 500 && midy != 10'd459; i++) tick();
      chk("at_459", 16'(midy), 16'd459);
      step(1, 1, 0, 0, 1);
      chk("both_score", 16'(score), 16'd1);
      chk("both_miss", 16'(miss), 16'd0);
      chk("both_lives", 16'(lives), 16'd2);
      chk("both_show", 16'(show), 16'd0);
      step(1, 0, 0, 0, 0);

      // run out of lives, then restart
      wait_spawn();
      fall_floor();
      chk("lives_1", 16'(lives), 16'd1);
      wait_spawn();
      fall_floor();
      chk("lives_0", 16'(lives), 16'd0);
      chk("over_set", 16'(game_over), 16'd1);
      chk("over_show", 16'(show), 16'd0);
      step(1, 0, 0, 0, 0);
      chk("over_hold", 16'(game_over), 16'd1);
      step(1, 0, 1, 0, 0);
      chk("restart_lives", 16'(lives), 16'd3);
      chk("restart_score", 16'(score), 16'd0);
      chk("restart_over", 16'(game_over), 16'd0);
      step(1, 0, 0, 0, 1);
      chk("hit_in_wait", 16'(score), 16'd0);
      for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0);
      step(1, 0, 1, 0, 0);

      // pause during fall, hit still counts
      wait_spawn();
      tick(); tick(); tick();
      chk("pre_pause", 16'(midy), 16'd23);
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 0, 1, 0);
         chk("pause_hold", 16'(midy), 16'd23);
      end
      step(1, 1, 0, 1, 1);
      chk("pause_hit_score", 16'(score), 16'd1);
      chk("pause_hit_show", 16'(show), 16'd0);
      step(1, 0, 0, 0, 0);

      // reset mid-fall with pending hit and tick
      wait_spawn();
      tick(); tick();
      step(0, 1, 0, 0, 1);
      chk_reset();
      for (int i = 0; i < 40; i++) tick();
      chk("idle_no_spawn", 16'(show), 16'd0);
      step(1, 0, 1, 0, 0);

      // eight catches raise the speed
      for (int k = 0; k < 8; k++) begin
         wait_spawn();
         tick();
         step(1, 1, 0, 0, 1);
      end
      chk("catch8_score", 16'(score), 16'd8);
      wait_spawn();
      chk("lvl1_start", 16'(midy), 16'd20);
      tick();
      chk("lvl1_22", 16'(midy), 16'd22);
      tick();
      chk("lvl1_24", 16'(midy), 16'd24);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tp_spawner.md
TP_SPAWNER -- requirements
Module: tp_spawner

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning), one per line:
- X_MIN, 64: leftmost spawn centre x.
- Y_START, 20: spawn centre y.
- Y_BOTTOM, 460: floor centre y.
- WAIT_FRAMES, 30: frames hidden between objects.
- LIVES, 3: misses allowed before game over.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line:
- clk, in, 1: system clock.
- rst_n, in, 1: reset; one clock, synchronous, active-low.
- frame_tick, in, 1: one-cycle pulse per video frame.
- start, in, 1: begin/restart game.
- pause, in, 1: freeze motion and counters.
- hit, in, 1: pulse when the player catches the object.
- show, out, 1: object visible; feeds the shape renderer.
- id, out, 2: shape select 0..3.
- midx, out, 10: object centre x.
- midy, out, 10: object centre y.
- score, out, 8: caught count, saturating.
- lives, out, 2: remaining lives.
- miss, out, 1: one-cycle pulse on floor contact.
- game_over, out, 1: high in OVER state.

Function
REQ-003 The block SHALL use FSM states IDLE, WAIT, FALL, OVER; all outputs SHALL be registered.
REQ-004 The block SHALL contain a 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1 that advances every clk cycle in every state.
REQ-005 A frame_tick SHALL be "effective" only when pause=0; while pause=1, the state, the position and all counters SHALL hold.
REQ-006 In IDLE, start=1 SHALL enter WAIT, load frame counter to 0, score=0 and lives=LIVES; start in any other state except OVER SHALL be ignored.
REQ-007 In WAIT, each effective frame_tick SHALL increment the frame counter, and the frame_tick that makes the count equal WAIT_FRAMES SHALL spawn and enter FALL in the same cycle.
REQ-008 On spawn, the block SHALL set id=lfsr[1:0], midx=X_MIN+{1'b0,lfsr[14:6]} (range X_MIN..X_MIN+511), midy=Y_START, show=1, and increment the spawn counter.
REQ-009 The fall speed SHALL be 1+level pixels per effective frame_tick, where level=min(spawn_count/8, 3); the spawn counter SHALL be 5 bits and saturate at 31.
REQ-010 In FALL, on an effective frame_tick with no hit: if midy+speed >= Y_BOTTOM, the block SHALL set midy=Y_BOTTOM, show=0, pulse miss for one cycle, decrement lives, and enter OVER if lives becomes 0, else WAIT with the frame counter cleared; otherwise the block SHALL set midy=midy+speed.
REQ-011 In FALL, hit=1 SHALL set show=0, increment score (saturating at 255), clear the frame counter and enter WAIT; hit SHALL take priority over floor contact in the same cycle and SHALL act even when pause=1.
REQ-012 hit outside FALL SHALL be ignored.
REQ-013 In OVER, the block SHALL hold game_over=1 and show=0; start=1 SHALL behave as in IDLE (clear score, lives=LIVES, spawn counter=0, enter WAIT) and deassert game_over.
REQ-014 id and midx SHALL hold their values when show=0 until the next spawn.
REQ-015 All arithmetic SHALL be unsigned, 10-bit for positions with an 11-bit intermediate for the floor compare, so there is no wrap-around.

Reset
REQ-016 rst_n=0 at a clk edge SHALL force IDLE, show=0, id=0, midx=0, midy=Y_START, score=0, lives=LIVES, miss=0, game_over=0, counters=0 and LFSR=16'hACE1, including mid-fall, with no pending miss or score update surviving.

Verification
REQ-017 The bench SHALL cover the following scenarios:
- Reset, start, then 30 frame_ticks: show rises on the 30th tick with midy=20, id=lfsr[1:0] and midx in 64..575.
- Level 0 with no hit: midy steps 21, 22, …; the tick reaching 460 gives midy=460, a one-cycle miss pulse and lives 3->2.
- hit and floor contact on the same tick: score +1, no miss, lives unchanged.
- Three misses: game_over=1, show=0; start then restores lives=3, score=0 and WAIT.
- pause held for 10 ticks during FALL: midy unchanged; a hit during the pause is still counted.
- rst_n pulsed mid-fall: the next cycle shows the REQ-016 values and state IDLE.
- 8 catches: the next object falls 2 pixels per tick.
